alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU operation interface (aluop/a/b -> registered f, 1-cycle latency, no valid).
//  Accepts tagged ops on a valid/ready request port and drives the ALU operand/opcode inputs.
//  Tracks in-flight ops and captures each ALU result, with its tag, into a response FIFO.
//  Presents results on a valid/ready response port. Sits between the execute front-end and the ALU.
// PARAMETERS
//  ALU_LAT     1   ALU result latency in clocks (ALU registers f on posedge).
//  RESP_DEPTH  4   response FIFO entries (power of 2, >=2).
//  TAG_W       4   request/response tag width.
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      asynchronous reset, active-high
//  req_valid  in   1      request valid
//  req_ready  out  1      request accepted when valid&ready at posedge
//  req_op     in   3      alu_op_t opcode (000 add,001 sll,010 sra,011 sub,100 xor,101 srl,110 or,111 and)
//  req_a      in   32     operand a
//  req_b      in   32     operand b
//  req_tag    in   TAG_W  caller tag, returned with result
//  alu_aluop  out  3      to ALU aluop
//  alu_a      out  32     to ALU a
//  alu_b      out  32     to ALU b
//  alu_f      in   32     from ALU f, valid ALU_LAT cycles after issue
//  rsp_valid  out  1      response valid
//  rsp_ready  in   1      response consumed when valid&ready at posedge
//  rsp_data   out  32     result
//  rsp_tag    out  TAG_W  tag of the result
// BEHAVIOUR
//  - Reset (async assert): in-flight pipe cleared, FIFO empty; rsp_valid=0, rsp_data=0, rsp_tag=0, req_ready=0 while rst high.
//  - alu_aluop/a/b combinationally = req_op/a/b when req_valid, else 3'b000/0/0 (never X into ALU).
//  - Credit rule: req_ready = !rst && (fifo_count + inflight_count) < RESP_DEPTH; counts in the same cycle
//    (a pop this cycle does NOT add credit this cycle; no comb path rsp_ready->req_ready).
//  - Issue at edge N: {1,tag} enters valid/tag shift pipe of length ALU_LAT; at edge N+ALU_LAT+... the pipe
//    output with alu_f is pushed into FIFO at edge N+ALU_LAT (alu_f sampled during cycle after N).
//    Min latency req handshake -> rsp_valid high: ALU_LAT+1 edges (2 by default).
//  - Back-to-back issue every cycle sustained while rsp_ready=1; results return in issue order.
//  - ALU f ignored whenever pipe output valid=0 (f is X after reset and is not reset by the ALU).
//  - Push and pop in same cycle: count unchanged, both pointers advance; pop of empty never occurs.
//  - Credit rule guarantees push never sees full FIFO; assertion: push && full is an error.
//  - rsp_data/rsp_tag stable while rsp_valid && !rsp_ready.
//  - Pointers wrap modulo RESP_DEPTH with extra MSB for full/empty.
//  - Reset mid-operation drops all in-flight and buffered results; no response after deassert
//    until a new request is accepted.
// STRUCTURE
//  - Package alu_pkg: typedef enum logic [2:0] alu_op_t (ALU_ADD..ALU_AND as above); localparam ALU_W=32.
//  - Sub-module alu_resp_fifo (#(DEPTH,W)): sync FIFO, async active-high rst, push/pop/full/empty/count.
//  - Top holds issue mux, ALU_LAT-deep valid/tag shift register, inflight/credit counters.
// TESTING
//  1 Reset: rst=1 -> rsp_valid=0, req_ready=0; release -> req_ready=1, rsp_valid=0 forever w/o requests.
//  2 Single add: op=000 a=5 b=3 tag=2, rsp_ready=1 -> rsp_valid 2 edges later, rsp_data=8, rsp_tag=2.
//  3 Shift/sign: sra a=32'h8000_0000 b=4 -> 32'hF800_0000; srl same -> 32'h0800_0000;
//    sll a=1 b=32'h25 -> 32'h20 (only b[4:0] used); sub a=0 b=1 -> 32'hFFFF_FFFF.
//  4 Backpressure: rsp_ready=0, issue 4 ops tags 0..3 -> req_ready=0 after 4th accept; raise rsp_ready ->
//    results drain in order 0..3, req_ready returns 1 the cycle after first pop.
//  5 Streaming: 16 random ops back-to-back, rsp_ready=1 -> one accept/cycle, results match golden model, in order.
//  6 Reset mid-flight: issue 3 ops, assert rst between issue and response -> no stale response after release;
//    next op (xor a=32'hFF b=32'h0F tag=7) returns 32'hF0, tag 7.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encoding and datapath width.
//   ALU_W    : ALU operand/result width
//   alu_op_t : 3-bit ALU opcode
package alu_pkg;
    localparam int ALU_W = 32;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_op_t;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response handshake bundle between the execute front-end and alu_issue_ctrl.
//   req_valid/req_ready/req_op/req_a/req_b/req_tag : tagged op request
//   rsp_valid/rsp_ready/rsp_data/rsp_tag          : tagged result response
//   master : front-end view, slave : controller view
interface alu_issue_if #(parameter int TAG_W = 4);
    import alu_pkg::*;
    logic             req_valid;
    logic             req_ready;
    alu_op_t          req_op;
    logic [ALU_W-1:0] req_a;
    logic [ALU_W-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ALU_W-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/alu_resp_fifo.sv
// alu_resp_fifo: synchronous FIFO holding ALU results until the response port takes them.
//   clk, rst        : clock, async active-high reset
//   i_push, i_din   : write strobe and data
//   i_pop, o_dout   : read strobe and head data (zero when empty)
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries
module alu_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + (AW+1)'(1);
            if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end
    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_count = r_wr - r_rd;
    // Storage is not reset, so the head is masked to keep outputs clean while empty.
    assign o_dout  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues tagged ops to a fixed-latency ALU and returns tagged results in order.
//   clk, rst               : clock, async active-high reset
//   bus (slave)            : request/response handshake bundle
//   o_alu_aluop/a/b        : ALU opcode and operands (zero when no request)
//   i_alu_f                : ALU result, valid ALU_LAT cycles after issue
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT    = 1,
    parameter int RESP_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_if.slave       bus,
    output alu_op_t          o_alu_aluop,
    output logic [ALU_W-1:0] o_alu_a,
    output logic [ALU_W-1:0] o_alu_b,
    input  logic [ALU_W-1:0] i_alu_f
);
    localparam int CW = $clog2(RESP_DEPTH) + 2;
    logic                         w_issue;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(RESP_DEPTH):0]  w_count;
    logic [ALU_W+TAG_W-1:0]       w_head;
    logic [CW-1:0]                r_inflight;
    logic [ALU_LAT-1:0]           r_pv;
    logic [TAG_W-1:0]             r_pt [ALU_LAT];
    always_comb begin
        o_alu_aluop = bus.req_valid ? bus.req_op : ALU_ADD;
        o_alu_a     = bus.req_valid ? bus.req_a  : '0;
        o_alu_b     = bus.req_valid ? bus.req_b  : '0;
    end
    // Every issued op owns a FIFO slot from issue until pop; pops only free credit next cycle.
    assign bus.req_ready = !rst && ((CW'(w_count) + r_inflight) < CW'(RESP_DEPTH));
    assign w_issue       = bus.req_valid && bus.req_ready;
    assign w_push        = r_pv[ALU_LAT-1];
    assign w_pop         = bus.rsp_ready && !w_empty;
    assign bus.rsp_valid = !w_empty;
    assign {bus.rsp_tag, bus.rsp_data} = w_head;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv       <= '0;
            r_inflight <= '0;
            for (int i = 0; i < ALU_LAT; i++) r_pt[i] <= '0;
        end else begin
            r_pv[0] <= w_issue;
            r_pt[0] <= bus.req_tag;
            for (int i = 1; i < ALU_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
        end
    end
    alu_resp_fifo #(.DEPTH(RESP_DEPTH), .W(ALU_W + TAG_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({r_pt[ALU_LAT-1], i_alu_f}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    // Credit accounting must make overflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and result queue model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;
    logic        clk = 0;
    logic        rst = 1;
    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_f;
    int          n_cmp = 0;
    int          n_err = 0;

    alu_issue_if #(.TAG_W(4)) bus ();

    alu_issue_ctrl #(.ALU_LAT(1), .RESP_DEPTH(4), .TAG_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_alu_aluop (alu_op),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .i_alu_f     (alu_f)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(alu_op_t op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SLL: return a << b[4:0];
            ALU_SRA: return $signed(a) >>> b[4:0];
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SRL: return a >> b[4:0];
            ALU_OR:  return a | b;
            default: return a & b;
        endcase
    endfunction

    // Stand-in ALU: registered result, one cycle latency.
    always_ff @(posedge clk) alu_f <= alu_fn(alu_op, alu_a, alu_b);

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic do_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         output logic [31:0] d, output logic [3:0] t, output int lat, output bit ok);
        int guard = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        bus.rsp_ready = 1;
        #1;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(negedge clk);
        bus.req_valid = 0;
        lat = 1;
        #1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        ok = bus.rsp_valid && guard < 20;
        d  = bus.rsp_data;
        t  = bus.rsp_tag;
    endtask

    task automatic test_reset();
        bit seen = 0;
        rst = 1;
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.rsp_data !== 32'h0 || bus.rsp_tag !== 4'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h/%h want 0/0", bus.rsp_data, bus.rsp_tag); end
        @(negedge clk);
        rst = 0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL release_req_ready: got %b want 1", bus.req_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b0) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL idle_rsp_valid: got %b want 0", seen); end
    endtask

    task automatic test_single_add();
        logic [31:0] d; logic [3:0] t; int lat; bit ok;
        do_op(ALU_ADD, 32'd5, 32'd3, 4'd2, d, t, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL add_resp: got valid %b want 1", ok); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_cmp++; if (d !== 32'd8) begin n_err++; $display("FAIL add_data: got %h want 00000008", d); end
        n_cmp++; if (t !== 4'd2) begin n_err++; $display("FAIL add_tag: got %0d want 2", t); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_pop: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_shift_sign();
        alu_op_t     ops [4] = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SUB};
        logic [31:0] as  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h0};
        logic [31:0] bs  [4] = '{32'd4, 32'd4, 32'h25, 32'h1};
        logic [31:0] ex  [4] = '{32'hF800_0000, 32'h0800_0000, 32'h20, 32'hFFFF_FFFF};
        logic [31:0] d; logic [3:0] t; int lat; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 4'(i + 8), d, t, lat, ok);
            n_cmp++; if (!ok || d !== ex[i]) begin n_err++; $display("FAIL shift_%0d: got %h valid %b want %h", i, d, ok, ex[i]); end
            n_cmp++; if (t !== 4'(i + 8)) begin n_err++; $display("FAIL shift_tag_%0d: got %0d want %0d", i, t, i + 8); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [35:0] exp_q [$];
        alu_op_t op; logic [31:0] a, b;
        bus.rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = alu_op_t'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = 4'(i);
            #1;
            n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept_%0d: ready %b want 1", i, bus.req_ready); end
            exp_q.push_back({4'(i), alu_fn(op, a, b)});
        end
        @(negedge clk);
        bus.req_valid = 0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", bus.req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold: valid %b ready %b want 1/0", bus.rsp_valid, bus.req_ready); end
        @(negedge clk); #1;
        n_cmp++; if ({bus.rsp_tag, bus.rsp_data} !== exp_q[0]) begin n_err++; $display("FAIL bp_stable: got %h want %h", {bus.rsp_tag, bus.rsp_data}, exp_q[0]); end
        bus.rsp_ready = 1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            n_cmp++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_tag, bus.rsp_data} !== exp_q[j]) begin
                n_err++; $display("FAIL bp_drain_%0d: got %b %h want 1 %h", j, bus.rsp_valid, {bus.rsp_tag, bus.rsp_data}, exp_q[j]);
            end
            if (j < 2) begin
                n_cmp++; if (bus.req_ready !== 1'(j)) begin n_err++; $display("FAIL bp_credit_%0d: got %b want %0d", j, bus.req_ready, j); end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_streaming();
        logic [35:0] exp_q [$];
        logic [35:0] got_q [$];
        int sent = 0, cyc = 0;
        bit stall = 0;
        alu_op_t op; logic [31:0] a, b; logic [3:0] tg;
        bus.rsp_ready = 1;
        while ((sent < 16 || got_q.size() < 16) && cyc < 100) begin
            @(negedge clk);
            if (sent < 16) begin
                op = alu_op_t'($urandom_range(0, 7)); a = $urandom; b = $urandom; tg = 4'($urandom_range(0, 15));
                bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tg;
            end else bus.req_valid = 0;
            #1;
            if (bus.rsp_valid) got_q.push_back({bus.rsp_tag, bus.rsp_data});
            if (sent < 16) begin
                if (bus.req_ready) begin exp_q.push_back({tg, alu_fn(op, a, b)}); sent++; end
                else stall = 1;
            end
            cyc++;
        end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL stream_stall: got %b want 0", stall); end
        n_cmp++; if (got_q.size() != 16) begin n_err++; $display("FAIL stream_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stream_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        bit seen = 0;
        logic [31:0] d; logic [3:0] t; int lat; bit ok;
        bus.rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1; bus.req_op = ALU_ADD; bus.req_a = $urandom; bus.req_b = $urandom; bus.req_tag = 4'(i);
        end
        @(negedge clk);
        bus.req_valid = 0;
        rst = 1;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset: valid %b ready %b want 0/0", bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        rst = 0;
        bus.rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b0) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %b want 0", seen); end
        do_op(ALU_XOR, 32'hFF, 32'h0F, 4'd7, d, t, lat, ok);
        n_cmp++; if (!ok || d !== 32'hF0) begin n_err++; $display("FAIL mid_xor: got %h valid %b want 000000f0", d, ok); end
        n_cmp++; if (t !== 4'd7) begin n_err++; $display("FAIL mid_tag: got %0d want 7", t); end
    endtask

    initial begin
        bus.req_valid = 0; bus.req_op = ALU_ADD; bus.req_a = 0; bus.req_b = 0; bus.req_tag = 0; bus.rsp_ready = 0;
        test_reset();
        test_single_add();
        test_shift_sign();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
